lab3_sr_latch_checker: RTL and testbench

LAB3_SR_LATCH_CHECKER -- requirements
Module: lab3_sr_latch_checker

---
 rtl/lab3_pkg.sv | 21 ++
 rtl/lab3_sr_latch_checker.sv | 158 +++++++++++++++
 tb/tb_lab3_sr_latch_checker.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lab3_pkg.sv
// Shared encodings for the SR latch checker.
// Command and FSM state types used by the checker and its bench.
package lab3_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_SET  = 2'b01,
        CMD_RST  = 2'b10,
        CMD_BAD  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        RELEASE = 2'b10,
        CHECK   = 2'b11
    } state_e;

    localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/lab3_sr_latch_checker.sv
// Drives S/R into an external latch for a fixed settle time,
// then checks Q/NQ against the expected latch state.
module lab3_sr_latch_checker
    import lab3_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       S,
    output logic       R,
    input  logic       Q,
    input  logic       NQ,
    output logic       pass,
    output logic       err,
    output logic [7:0] err_count,
    output logic       exp_valid,
    output logic       exp_q
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q;
    state_e     state_d;
    cmd_e       cmd_q;
    logic [3:0] cnt_q;
    logic       bad_ok_q;
    logic       chk_en;
    logic       match;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and the CHECK-cycle verdict.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        chk_en    = 1'b0;
        match     = 1'b0;
        pass      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = DRIVE;
            end
            DRIVE: begin
                if (cnt_q == 4'd0) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                unique case (cmd_q)
                    CMD_SET: begin
                        chk_en = 1'b1;
                        match  = Q & ~NQ;
                    end
                    CMD_RST: begin
                        chk_en = 1'b1;
                        match  = ~Q & NQ;
                    end
                    CMD_HOLD: begin
                        chk_en = exp_valid;
                        match  = (Q == exp_q) && (NQ == ~exp_q);
                    end
                    CMD_BAD: begin
                        chk_en = 1'b1;
                        match  = bad_ok_q;
                    end
                    default: begin
                        chk_en = 1'b0;
                    end
                endcase
                pass = chk_en & match;
                err  = chk_en & ~match;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command capture, S/R drive timing and forbidden-state sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q    <= CMD_HOLD;
            cnt_q    <= 4'd0;
            S        <= 1'b0;
            R        <= 1'b0;
            bad_ok_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q <= cmd_e'(cmd);
                        S     <= cmd[0];
                        R     <= cmd[1];
                        cnt_q <= CNT_LOAD;
                    end
                end
                DRIVE: begin
                    if (cnt_q == 4'd0) begin
                        S        <= 1'b0;
                        R        <= 1'b0;
                        bad_ok_q <= ~Q & ~NQ;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    S <= 1'b0;
                    R <= 1'b0;
                end
            endcase
        end
    end

    // Expected latch state and saturating mismatch count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid <= 1'b0;
            exp_q     <= 1'b0;
            err_count <= 8'd0;
        end else if (state_q == CHECK) begin
            unique case (cmd_q)
                CMD_SET: begin
                    exp_valid <= 1'b1;
                    exp_q     <= 1'b1;
                end
                CMD_RST: begin
                    exp_valid <= 1'b1;
                    exp_q     <= 1'b0;
                end
                CMD_BAD: begin
                    exp_valid <= 1'b0;
                end
                default: begin
                    exp_valid <= exp_valid;
                end
            endcase
            if (err && err_count != ERR_MAX) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lab3_sr_latch_checker.sv
// Bench for the SR latch checker with a NOR latch model,
// fault injection and a queue-based scoreboard.
module tb_lab3_sr_latch_checker;
    import lab3_pkg::*;

    localparam int SETTLE = 2;

    typedef struct {
        logic [1:0] c;
        logic       f;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready;
    logic       S;
    logic       R;
    logic       Q;
    logic       NQ;
    logic       pass;
    logic       err;
    logic [7:0] err_count;
    logic       exp_valid;
    logic       exp_q;
    logic       fault = 1'b0;
    logic       lq = 1'b0;

    int checks = 0;
    int errors = 0;

    item_t q_sb[$];
    item_t cur;
    int    cd = 0;
    bit    post = 1'b0;
    logic  m_ev = 1'b0;
    logic  m_eq = 1'b0;
    int    m_cnt = 0;
    int    cyc = 0;
    int    last_acc = -1;
    int    last_gap = 0;
    int    acc_cnt = 0;

    always #5 clk = ~clk;

    lab3_sr_latch_checker #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_ready(cmd_ready),
        .S(S),
        .R(R),
        .Q(Q),
        .NQ(NQ),
        .pass(pass),
        .err(err),
        .err_count(err_count),
        .exp_valid(exp_valid),
        .exp_q(exp_q)
    );

    // NOR latch: S=R=1 pulls both outputs low; release keeps old state.
    always @(S or R) begin
        if (S && !R) lq = 1'b1;
        else if (R && !S) lq = 1'b0;
    end
    assign Q  = fault ? 1'b0 : ((S && R) ? 1'b0 : lq);
    assign NQ = (S && R) ? 1'b0 : ~lq;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: push on handshake, judge in CHECK, state one cycle later.
    always @(negedge clk) begin
        logic [1:0] ep;
        bit         drv;
        item_t      it;
        cyc++;
        if (rst) begin
            q_sb.delete();
            cd = 0;
            post = 1'b0;
            m_ev = 1'b0;
            m_eq = 1'b0;
            m_cnt = 0;
            last_acc = -1;
        end else begin
            if (post) begin
                chk("exp_valid", exp_valid, m_ev);
                chk("exp_q", exp_q, m_eq);
                chk("err_count", err_count, m_cnt);
                post = 1'b0;
            end
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    it = q_sb.pop_front();
                    ep = 2'b00;
                    case (it.c)
                        CMD_SET: begin
                            ep = it.f ? 2'b01 : 2'b10;
                            m_ev = 1'b1;
                            m_eq = 1'b1;
                        end
                        CMD_RST: begin
                            ep = 2'b10;
                            m_ev = 1'b1;
                            m_eq = 1'b0;
                        end
                        CMD_HOLD: begin
                            ep = m_ev ? 2'b10 : 2'b00;
                        end
                        default: begin
                            ep = 2'b10;
                            m_ev = 1'b0;
                        end
                    endcase
                    if (ep[0] && m_cnt < 255) m_cnt++;
                    chk("pass_err", {pass, err}, ep);
                    chk("ready_check", cmd_ready, 0);
                    post = 1'b1;
                end else begin
                    drv = (cd >= 2);
                    chk("ready_busy", cmd_ready, 0);
                    chk("s_drive", S, drv ? cur.c[0] : 1'b0);
                    chk("r_drive", R, drv ? cur.c[1] : 1'b0);
                    chk("no_pulse", {pass, err}, 0);
                end
            end else begin
                chk("ready_idle", cmd_ready, 1);
                chk("sr_idle", {S, R}, 0);
                chk("no_pulse", {pass, err}, 0);
                if (cmd_valid && cmd_ready) begin
                    cur.c = cmd;
                    cur.f = fault;
                    q_sb.push_back(cur);
                    cd = SETTLE + 2;
                    acc_cnt++;
                    if (last_acc >= 0) last_gap = cyc - last_acc;
                    last_acc = cyc;
                end
            end
        end
    end

    task automatic send(input logic [1:0] c);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd = c;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", n < 20, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (SETTLE + 3) @(posedge clk);
    endtask

    initial begin
        int a0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sr", {S, R}, 0);
        chk("rst_pulse", {pass, err}, 0);
        chk("rst_cnt", err_count, 0);
        chk("rst_exp", {exp_valid, exp_q}, 0);
        rst = 1'b0;

        send(CMD_SET);
        chk("set_q", exp_q, 1);
        chk("set_v", exp_valid, 1);

        send(CMD_RST);
        send(CMD_HOLD);
        chk("hold_q", Q, 0);
        chk("hold_nq", NQ, 1);
        chk("hold_exp", exp_q, 0);

        send(CMD_BAD);
        chk("bad_v", exp_valid, 0);
        send(CMD_HOLD);
        send(CMD_SET);
        send(CMD_HOLD);

        fault = 1'b1;
        send(CMD_SET);
        chk("fault_cnt1", err_count, 1);
        repeat (299) send(CMD_SET);
        chk("fault_sat", err_count, 255);
        fault = 1'b0;

        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd = CMD_SET;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("mid_s_on", S, 1);
        rst = 1'b1;
        #1;
        chk("mid_s_off", S, 0);
        chk("mid_pulse", {pass, err}, 0);
        chk("mid_cnt", err_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", cmd_ready, 1);
        repeat (SETTLE + 3) @(posedge clk);

        @(posedge clk);
        #1;
        a0 = acc_cnt;
        cmd = CMD_SET;
        cmd_valid = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("stream_acc", acc_cnt - a0, 5);
        chk("stream_gap", last_gap, SETTLE + 3);
        repeat (SETTLE + 4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
